// File: rtl/qf_rw_arb.sv
// qf_rw_arb: round-robin two-master arbiter/sequencer for a qf_rw register bank.
// Optional write lock for master 1 is enabled by defining QF_RW_ARB_LOCK_EN.
module qf_rw_arb #(
  parameter int PAR_BIT_WIDTH  = 32,
  parameter int PAR_ADDR_WIDTH = 4
) (
  input  logic                                        sys_clk,
  input  logic                                        sys_rst_n,
`ifdef QF_RW_ARB_LOCK_EN
  input  logic                                        cfg_lock,
  output logic                                        m1_err,
`endif
  input  logic                                        m0_req,
  input  logic                                        m0_wr,
  input  logic [PAR_ADDR_WIDTH-1:0]                   m0_addr,
  input  logic [PAR_BIT_WIDTH-1:0]                    m0_wdata,
  output logic                                        m0_gnt,
  output logic                                        m0_rvalid,
  output logic [PAR_BIT_WIDTH-1:0]                    m0_rdata,
  input  logic                                        m1_req,
  input  logic                                        m1_wr,
  input  logic [PAR_ADDR_WIDTH-1:0]                   m1_addr,
  input  logic [PAR_BIT_WIDTH-1:0]                    m1_wdata,
  output logic                                        m1_gnt,
  output logic                                        m1_rvalid,
  output logic [PAR_BIT_WIDTH-1:0]                    m1_rdata,
  output logic [(2**PAR_ADDR_WIDTH)-1:0]              reg_wr_en,
  output logic [PAR_BIT_WIDTH-1:0]                    reg_wrdata,
  input  logic [(2**PAR_ADDR_WIDTH)*PAR_BIT_WIDTH-1:0] reg_rddata
);
  localparam int NREG = 2**PAR_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                          r_state, w_state_nxt;
  logic                            r_win;   // 0 = m0, 1 = m1
  logic                            r_last;  // master served last
  logic                            r_wr;
  logic [PAR_ADDR_WIDTH-1:0]       r_addr;
  logic [PAR_BIT_WIDTH-1:0]        r_wdata;
  logic [1:0][PAR_BIT_WIDTH-1:0]   r_rdata;
  logic                            w_win;
  logic                            w_any;
  logic                            w_acc;
  logic                            w_resp;
  logic                            w_wr_ok;
  logic [NREG-1:0][PAR_BIT_WIDTH-1:0] w_rd_arr;

  assign w_rd_arr = reg_rddata;
  assign w_any    = m0_req | m1_req;
  // On a tie the master that was not served last wins.
  assign w_win    = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_acc    = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);

`ifdef QF_RW_ARB_LOCK_EN
  logic r_m1_err;
  assign w_wr_ok = w_acc & r_wr & ~(r_win & cfg_lock);
  assign m1_err  = r_m1_err;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_m1_err <= 1'b0;
    else            r_m1_err <= w_acc & r_wr & r_win & cfg_lock;
  end
`else
  assign w_wr_ok = w_acc & r_wr;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_win   <= 1'b0;
      r_last  <= 1'b1;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_win   <= w_win;
        r_wr    <= w_win ? m1_wr    : m0_wr;
        r_addr  <= w_win ? m1_addr  : m0_addr;
        r_wdata <= w_win ? m1_wdata : m0_wdata;
      end
      if (w_acc) begin
        r_last <= r_win;
        if (!r_wr) r_rdata[r_win] <= w_rd_arr[r_addr];
      end
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_wr_en
    assign reg_wr_en[i] = w_wr_ok && (r_addr == PAR_ADDR_WIDTH'(i));
  end

  assign reg_wrdata = r_wdata;
  assign m0_gnt     = w_acc  & ~r_win;
  assign m1_gnt     = w_acc  &  r_win;
  assign m0_rvalid  = w_resp & ~r_win;
  assign m1_rvalid  = w_resp &  r_win;
  assign m0_rdata   = r_rdata[0];
  assign m1_rdata   = r_rdata[1];
endmodule

// File: tb/tb_qf_rw_arb.sv
// Directed self-checking bench for qf_rw_arb with a behavioural register bank.
module tb_qf_rw_arb;
  localparam int W    = 32;
  localparam int AW   = 4;
  localparam int NREG = 2**AW;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [W-1:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [NREG-1:0]   reg_wr_en;
  logic [W-1:0]      reg_wrdata;
  logic [NREG*W-1:0] reg_rddata;
`ifdef QF_RW_ARB_LOCK_EN
  logic cfg_lock, m1_err;
`endif

  logic [W-1:0] bank [NREG];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  qf_rw_arb #(.PAR_BIT_WIDTH(W), .PAR_ADDR_WIDTH(AW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
`ifdef QF_RW_ARB_LOCK_EN
    .cfg_lock(cfg_lock), .m1_err(m1_err),
`endif
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .reg_wr_en(reg_wr_en), .reg_wrdata(reg_wrdata), .reg_rddata(reg_rddata)
  );

  // Register bank: default value 0xA000_000i, written on the strobe.
  initial for (int i = 0; i < NREG; i++) bank[i] = 32'hA000_0000 + i;
  always @(posedge sys_clk)
    for (int i = 0; i < NREG; i++) if (reg_wr_en[i]) bank[i] <= reg_wrdata;
  always_comb
    for (int i = 0; i < NREG; i++) reg_rddata[i*W +: W] = bank[i];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}
  function automatic logic [3:0] strb();
    return {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_strb"},  {60'd0, strb()}, 64'd0);
    chk({tag, "_wren"},  {48'd0, reg_wr_en}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, reg_wrdata}, 64'd0);
    chk({tag, "_rdata"}, {m1_rdata, m0_rdata}, 64'd0);
  endtask

  task automatic do_reset;
    #2 sys_rst_n = 1'b0;
    #2 chk_reset("rst");
    sys_rst_n = 1'b1;
    tick();
  endtask

  logic [3:0] exp_gnt [1:9];
  logic [3:0] exp_rv  [1:9];

  initial begin
    sys_rst_n = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
`ifdef QF_RW_ARB_LOCK_EN
    cfg_lock = 1'b0;
`endif
    #12 chk_reset("por");
    sys_rst_n = 1'b1;
    tick();

    // m0 write then read of addr 3
    m0_req = 1; m0_wr = 1; m0_addr = 4'd3; m0_wdata = 32'hDEADBEEF;
    tick();
    chk("wr_gnt",  {60'd0, strb()}, 64'b0100);
    chk("wr_wren", {48'd0, reg_wr_en}, 64'h0008);
    chk("wr_data", {32'd0, reg_wrdata}, 64'hDEADBEEF);
    m0_req = 0;
    tick();
    chk("wr_rv",   {60'd0, strb()}, 64'b0001);
    chk("wr_wren0", {48'd0, reg_wr_en}, 64'd0);
    chk("wr_bank", {32'd0, bank[3]}, 64'hDEADBEEF);
    tick();
    m0_req = 1; m0_wr = 0;
    tick();
    chk("rd_gnt",  {60'd0, strb()}, 64'b0100);
    chk("rd_wren", {48'd0, reg_wr_en}, 64'd0);
    m0_req = 0;
    tick();
    chk("rd_rv",   {60'd0, strb()}, 64'b0001);
    chk("rd_data", {32'd0, m0_rdata}, 64'hDEADBEEF);
    tick();

    // tie after reset: m0 first, then alternate while both held
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 4'd1;
    m1_req = 1; m1_wr = 0; m1_addr = 4'd2;
    for (int k = 1; k <= 9; k++) begin exp_gnt[k] = 4'b0000; exp_rv[k] = 4'b0000; end
    exp_gnt[1] = 4'b0100; exp_gnt[4] = 4'b1000; exp_gnt[7] = 4'b0100;
    exp_rv[2]  = 4'b0001; exp_rv[5]  = 4'b0010; exp_rv[8]  = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("alt_c%0d", k), {60'd0, strb()}, {60'd0, exp_gnt[k] | exp_rv[k]});
    end
    m0_req = 0; m1_req = 0;
    chk("alt_rd0", {32'd0, m0_rdata}, 64'hA0000001);
    chk("alt_rd1", {32'd0, m1_rdata}, 64'hA0000002);

    // m1 writes 5 to addr 0, m0 queued read of addr 0 sees it
    m1_req = 1; m1_wr = 1; m1_addr = 4'd0; m1_wdata = 32'h5;
    m0_req = 1; m0_wr = 0; m0_addr = 4'd0;
    tick();
    chk("raw_gnt1", {60'd0, strb()}, 64'b1000);
    chk("raw_wren", {48'd0, reg_wr_en}, 64'h0001);
    m1_req = 0;
    tick();
    chk("raw_rv1", {60'd0, strb()}, 64'b0010);
    tick();
    tick();
    chk("raw_gnt0", {60'd0, strb()}, 64'b0100);
    m0_req = 0;
    tick();
    chk("raw_rv0", {60'd0, strb()}, 64'b0001);
    chk("raw_rd0", {32'd0, m0_rdata}, 64'h5);
    chk("raw_hold1", {32'd0, m1_rdata}, 64'hA0000002);
    tick();

    // reset during ACCESS of an m1 write to addr 7
    m1_req = 1; m1_wr = 1; m1_addr = 4'd7; m1_wdata = 32'hCAFEF00D;
    tick();
    chk("mid_gnt",  {60'd0, strb()}, 64'b1000);
    chk("mid_wren", {48'd0, reg_wr_en}, 64'h0080);
    #2 sys_rst_n = 1'b0;
    m1_req = 0;
    #1 chk_reset("mid");
    tick();
    chk("mid_bank", {32'd0, bank[7]}, 64'hA0000007);
    sys_rst_n = 1'b1;
    m0_req = 1; m0_wr = 0; m0_addr = 4'd0;
    m1_req = 1; m1_wr = 0; m1_addr = 4'd7; m1_wdata = 32'h12345678;
    tick();
    chk("post_gnt0", {60'd0, strb()}, 64'b0100);
    m0_req = 0;
    tick();
    chk("post_rd0", {32'd0, m0_rdata}, 64'h5);
    tick();
    tick();
    chk("post_gnt1", {60'd0, strb()}, 64'b1000);
    m1_req = 0;
    tick();
    chk("post_rv1", {60'd0, strb()}, 64'b0010);
    chk("post_rd1", {32'd0, m1_rdata}, 64'hA0000007);
    tick();

    // long idle: strobes low, write data held
    for (int k = 0; k < 120; k++) begin
      tick();
      chk($sformatf("idle_c%0d", k), {reg_wrdata, 12'd0, strb(), reg_wr_en},
          {32'h12345678, 32'd0});
    end

`ifdef QF_RW_ARB_LOCK_EN
    cfg_lock = 1'b1;
    m1_req = 1; m1_wr = 1; m1_addr = 4'd2; m1_wdata = 32'hFF;
    tick();
    chk("lk_gnt",  {60'd0, strb()}, 64'b1000);
    chk("lk_wren", {48'd0, reg_wr_en}, 64'd0);
    m1_req = 0;
    tick();
    chk("lk_err",  {59'd0, m1_err, strb()}, 64'b10010);
    chk("lk_bank", {32'd0, bank[2]}, 64'hA0000002);
    tick();
    chk("lk_err0", {63'd0, m1_err}, 64'd0);
    m0_req = 1; m0_wr = 1; m0_addr = 4'd2; m0_wdata = 32'h77;
    tick();
    chk("lk_m0wren", {48'd0, reg_wr_en}, 64'h0004);
    m0_req = 0;
    tick();
    chk("lk_m0err", {59'd0, m1_err, strb()}, 64'b00001);
    chk("lk_m0bank", {32'd0, bank[2]}, 64'h77);
    tick();
    cfg_lock = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qf_rw_arb.md
# qf_rw_arb

Two-master access arbiter and sequencer for a bank of `qf_rw` configuration registers in the FCB. It shares the bank between master 0 (host register port) and master 1 (internal FCB configuration engine) using round-robin arbitration. Each transaction is a three-cycle req/gnt/rvalid sequence. For every register in the bank, the block drives that register's `wr_en` and the shared `wrdata`, and it muxes the `rddata` buses back to the masters.

## Interface
- `PAR_BIT_WIDTH`, default 32: data width of each register.
- `PAR_ADDR_WIDTH`, default 4: register index width; bank size is NREG = 2**PAR_ADDR_WIDTH.
- `sys_clk`, in, 1: single clock; all state on its rising edge.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `m0_req` / `m1_req`, in, 1: access request; held high with stable command until gnt.
- `m0_wr` / `m1_wr`, in, 1: 1 = write, 0 = read.
- `m0_addr` / `m1_addr`, in, PAR_ADDR_WIDTH: register index.
- `m0_wdata` / `m1_wdata`, in, PAR_BIT_WIDTH: write data.
- `m0_gnt` / `m1_gnt`, out, 1: one-cycle command-accepted pulse.
- `m0_rvalid` / `m1_rvalid`, out, 1: one-cycle completion pulse, for reads and writes.
- `m0_rdata` / `m1_rdata`, out, PAR_BIT_WIDTH: read data; valid with rvalid; holds until that master's next read completes.
- `reg_wr_en`, out, NREG: one-hot write strobe to the register bank.
- `reg_wrdata`, out, PAR_BIT_WIDTH: shared write data to all registers.
- `reg_rddata`, in, NREG*PAR_BIT_WIDTH: flattened register outputs; register i is at bits [i*W +: W].

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any req is high, pick the winner and latch its wr, addr and wdata plus a winner id. Go to ACCESS.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Exactly one request: that master wins.
  - Both requesting: the master not served last wins.
  - Priority pointer resets to "m1 served last", so m0 wins the first tie.
  - Pointer updates only when a grant is issued.
- **ACCESS** (one cycle)
  - Assert the winner's gnt.
  - Write: `reg_wr_en[addr]` = 1 and `reg_wrdata` = latched wdata. The register updates at the end of this cycle.
  - Read: capture `reg_rddata[addr]` into the winner's rdata register.
  - Go to RESP.
- **RESP** (one cycle)
  - Assert the winner's rvalid.
  - Go to IDLE.
- The loser keeps req high and is served in the next transaction. The master is not re-arbitrated against a new req from the winner, because the pointer now favours the loser.
- A req that drops before gnt is a protocol violation; the block's behaviour is undefined.
- `reg_wrdata` retains its last latched value outside ACCESS. `reg_wr_en` is all-zero outside ACCESS.
- All addresses are valid, since the bank is fully decoded.

## Timing
- Reset values: all gnt, rvalid and `reg_wr_en` = 0; `reg_wrdata` = 0; both rdata = 0; state = IDLE; pointer = m1.
- Latency: req sampled high in IDLE at cycle 0, gnt in cycle 1, rvalid in cycle 2. Next arbitration happens in cycle 3.
- Throughput is one transaction per 3 cycles. Back-to-back requests alternate between masters when both are held.
- Read-after-write: a read issued in any later transaction returns the newly written value, because the register updates before the next ACCESS.
- Reset asserted mid-transaction: all outputs go immediately (asynchronously) to reset values. The transaction is dropped with no gnt and no rvalid, and any write not yet clocked is lost.
- All outputs are driven from flops or decoded from state flops only; there is no combinational path from req to gnt.

## Configuration
- `QF_RW_ARB_LOCK_EN` defined:
  - Adds input `cfg_lock` (1 bit) and output `m1_err` (1 bit, reset 0).
  - While `cfg_lock` = 1 in ACCESS, an m1 write is granted and completed normally, but `reg_wr_en` stays all-zero and `m1_err` pulses together with `m1_rvalid`.
  - m1 reads and all m0 accesses are unaffected.
- Macro undefined: the ports are absent and every write is performed.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to addr 3: m0_gnt in cycle 1 with `reg_wr_en` = 0x0008, m0_rvalid in cycle 2. m0 then reads addr 3 and gets `m0_rdata` = 0xDEADBEEF.
- m0 and m1 both request in the same cycle after reset: m0 is granted first, m1 is granted 3 cycles later. Held requests continue to alternate m0, m1, m0.
- m1 writes 0x5 to addr 0 while m0 queues a read of addr 0: m0 receives 0x5.
- Reset asserted during ACCESS of an m1 write to addr 7: register 7 keeps its default, all outputs are 0, and after release m0 is again the first-tie winner.
- With `QF_RW_ARB_LOCK_EN` and `cfg_lock` = 1, m1 writes 0xFF to addr 2: `reg_wr_en` stays 0, and m1_err and m1_rvalid pulse together. An m0 write to the same address still takes effect.
- Idle with no requests: all strobes stay 0 and `reg_wrdata` holds its last value for more than 100 cycles.
